// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next fetch address from branch-unit redirects,
// hazard/imem stalls and sequential flow, and flushes younger instructions after a redirect.
module pc_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        pc_srcs,
    input  logic              src_valid,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic [ADDR_W-1:0] j_target,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              stall_in,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              flush,
    output logic              redirect,
    output logic              misalign,
    output logic [15:0]       redirect_cnt
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [2:0]        FLUSH_INIT = 3'(FLUSH_CYCLES);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    logic [1:0]        state;
    logic [2:0]        fcnt;
    logic              adv;
    logic              take;
    logic [ADDR_W-1:0] tgt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        adv  = imem_ready & ~stall_in;
        take = src_valid & (pc_srcs != 2'b11);
        tgt  = br_target;
        case (pc_srcs)
            2'b00:   tgt = jr_target;
            2'b01:   tgt = j_target;
            default: tgt = br_target;
        endcase
    end

    // Flush is derived from the counter so it is high exactly while the counter is non-zero.
    assign flush = (fcnt != 3'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_BOOT;
            fcnt         <= 3'd0;
            pc           <= RESET_PC;
            pc_valid     <= 1'b0;
            redirect     <= 1'b0;
            misalign     <= 1'b0;
            redirect_cnt <= 16'd0;
        end else begin
            redirect <= 1'b0;
            misalign <= 1'b0;
            case (state)
                S_BOOT: begin
                    pc_valid <= 1'b1;
                    state    <= S_RUN;
                end
                S_RUN, S_STALL: begin
                    if (take) begin
                        // Redirect is accepted even while stalled; the target is then held.
                        pc           <= {tgt[ADDR_W-1:2], 2'b00};
                        redirect     <= 1'b1;
                        misalign     <= (tgt[1:0] != 2'b00);
                        redirect_cnt <= sat_inc(redirect_cnt);
                        fcnt         <= FLUSH_INIT;
                        state        <= S_FLUSH;
                    end else if (!adv) begin
                        state <= S_STALL;
                    end else begin
                        pc    <= pc + PC_STEP;
                        state <= S_RUN;
                    end
                end
                S_FLUSH: begin
                    // Control inputs here belong to flushed instructions and are ignored.
                    if (adv) begin
                        pc <= pc + PC_STEP;
                    end
                    if (fcnt <= 3'd1) begin
                        fcnt  <= 3'd0;
                        state <= adv ? S_RUN : S_STALL;
                    end else begin
                        fcnt <= fcnt - 3'd1;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: main instance with default flush length, second
// instance with a one-cycle flush used to drive the redirect counter into saturation.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  pc_srcs;
    logic        src_valid;
    logic [31:0] jr_target, j_target, br_target;
    logic        stall_in, imem_ready;
    logic [31:0] pc;
    logic        pc_valid, flush, redirect, misalign;
    logic [15:0] redirect_cnt;

    logic        reset2;
    logic        src_valid2;
    logic [31:0] pc2;
    logic        pc_valid2, flush2, redirect2, misalign2;
    logic [15:0] redirect_cnt2;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .pc_srcs(pc_srcs), .src_valid(src_valid),
        .jr_target(jr_target), .j_target(j_target), .br_target(br_target),
        .stall_in(stall_in), .imem_ready(imem_ready),
        .pc(pc), .pc_valid(pc_valid), .flush(flush), .redirect(redirect),
        .misalign(misalign), .redirect_cnt(redirect_cnt)
    );

    pc_sequencer #(.FLUSH_CYCLES(1)) dut2 (
        .clk(clk), .reset(reset2), .pc_srcs(2'b01), .src_valid(src_valid2),
        .jr_target(32'h0), .j_target(32'h0000_0400), .br_target(32'h0),
        .stall_in(1'b0), .imem_ready(1'b1),
        .pc(pc2), .pc_valid(pc_valid2), .flush(flush2), .redirect(redirect2),
        .misalign(misalign2), .redirect_cnt(redirect_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] exp_pc, input logic exp_flush,
                          input logic exp_redir);
        chk({tag, ".pc"}, pc, exp_pc);
        chk({tag, ".flush"}, 32'(flush), 32'(exp_flush));
        chk({tag, ".redirect"}, 32'(redirect), 32'(exp_redir));
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1; src_valid2 = 1'b0;
        pc_srcs = 2'b11; src_valid = 1'b0;
        jr_target = '0; j_target = '0; br_target = '0;
        stall_in = 1'b0; imem_ready = 1'b1;

        // Reset held for two edges
        tick();
        chk_pc("rst1", 32'h0, 1'b0, 1'b0);
        chk("rst1.pc_valid", 32'(pc_valid), 32'd0);
        chk("rst1.misalign", 32'(misalign), 32'd0);
        chk("rst1.cnt", 32'(redirect_cnt), 32'd0);
        tick();
        chk("rst2.pc", pc, 32'h0);
        chk("rst2.pc_valid", 32'(pc_valid), 32'd0);
        reset = 1'b0;

        tick();
        chk("boot.pc", pc, 32'h0);
        chk("boot.pc_valid", 32'(pc_valid), 32'd1);
        tick(); chk("seq.4", pc, 32'h4);
        // Sequential select with src_valid is not a redirect
        src_valid = 1'b1; pc_srcs = 2'b11;
        tick(); chk_pc("seq.8", 32'h8, 1'b0, 1'b0);
        src_valid = 1'b0;
        tick(); chk("seq.c", pc, 32'hC);
        tick(); chk("seq.10", pc, 32'h10);

        // Taken branch to 0x40; J requests during the flush must be ignored
        src_valid = 1'b1; pc_srcs = 2'b10; br_target = 32'h40;
        tick();
        chk_pc("br", 32'h40, 1'b1, 1'b1);
        chk("br.cnt", 32'(redirect_cnt), 32'd1);
        chk("br.misalign", 32'(misalign), 32'd0);
        pc_srcs = 2'b01; j_target = 32'h200;
        tick(); chk_pc("fl1", 32'h44, 1'b1, 1'b0);
        tick(); chk_pc("fl2", 32'h48, 1'b0, 1'b0);
        chk("fl2.cnt", 32'(redirect_cnt), 32'd1);
        src_valid = 1'b0;

        // Jump to 0x18, let the flush drain to reach 0x20 in RUN
        src_valid = 1'b1; pc_srcs = 2'b01; j_target = 32'h18;
        tick(); chk_pc("j18", 32'h18, 1'b1, 1'b1);
        src_valid = 1'b0;
        tick(); chk("j18.1c", pc, 32'h1C);
        tick(); chk_pc("j18.20", 32'h20, 1'b0, 1'b0);

        // Hazard stall for three edges
        stall_in = 1'b1;
        tick(); chk("st1", pc, 32'h20);
        tick(); chk("st2", pc, 32'h20);
        tick(); chk("st3", pc, 32'h20);
        stall_in = 1'b0;
        tick(); chk("st.rel", pc, 32'h24);

        // Same with instruction memory not ready
        imem_ready = 1'b0;
        tick(); chk("ir1", pc, 32'h24);
        tick(); chk("ir2", pc, 32'h24);
        tick(); chk("ir3", pc, 32'h24);
        imem_ready = 1'b1;
        tick(); chk("ir.rel", pc, 32'h28);

        // JR to a misaligned target while stalled: redirect wins, target is held
        stall_in = 1'b1; src_valid = 1'b1; pc_srcs = 2'b00; jr_target = 32'h103;
        tick();
        chk_pc("jr", 32'h100, 1'b1, 1'b1);
        chk("jr.misalign", 32'(misalign), 32'd1);
        chk("jr.cnt", 32'(redirect_cnt), 32'd3);
        src_valid = 1'b0;
        tick(); chk_pc("jr.h1", 32'h100, 1'b1, 1'b0);
        chk("jr.h1.misalign", 32'(misalign), 32'd0);
        tick(); chk_pc("jr.h2", 32'h100, 1'b0, 1'b0);
        tick(); chk("jr.h3", pc, 32'h100);
        stall_in = 1'b0;
        tick(); chk("jr.rel", pc, 32'h104);

        // Address wrap at the top of the space
        src_valid = 1'b1; pc_srcs = 2'b10; br_target = 32'hFFFF_FFF8;
        tick(); chk("wr.f8", pc, 32'hFFFF_FFF8);
        chk("wr.cnt", 32'(redirect_cnt), 32'd4);
        src_valid = 1'b0;
        tick(); chk("wr.fc", pc, 32'hFFFF_FFFC);
        tick(); chk("wr.0", pc, 32'h0);

        // Reset in the middle of a flush with the counter at 1
        src_valid = 1'b1; pc_srcs = 2'b01; j_target = 32'h80;
        tick(); chk("rf.j", pc, 32'h80);
        src_valid = 1'b0;
        tick(); chk_pc("rf.c1", 32'h84, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        chk_pc("rf.rst", 32'h0, 1'b0, 1'b0);
        chk("rf.cnt", 32'(redirect_cnt), 32'd0);
        chk("rf.pc_valid", 32'(pc_valid), 32'd0);
        reset = 1'b0;
        tick(); chk("rf.boot", 32'(pc_valid), 32'd1);
        tick(); chk("rf.seq", pc, 32'h4);

        // Back-to-back redirects on the one-cycle-flush instance until the counter saturates
        reset2 = 1'b0; src_valid2 = 1'b1;
        for (int c = 0; c < 140000 && pulses < 65540; c++) begin
            tick();
            if (redirect2) begin
                pulses++;
                if (pulses == 1) begin
                    chk("sat.first.cnt", 32'(redirect_cnt2), 32'd1);
                    chk("sat.first.pc", pc2, 32'h400);
                    chk("sat.first.flush", 32'(flush2), 32'd1);
                    chk("sat.first.misalign", 32'(misalign2), 32'd0);
                    chk("sat.first.pc_valid", 32'(pc_valid2), 32'd1);
                end
                if (pulses == 65534) chk("sat.fffe", 32'(redirect_cnt2), 32'hFFFE);
                if (pulses == 65535) chk("sat.ffff", 32'(redirect_cnt2), 32'hFFFF);
                if (pulses == 65540) chk("sat.hold", 32'(redirect_cnt2), 32'hFFFF);
            end
        end
        chk("sat.pulses", 32'(pulses), 32'd65540);
        src_valid2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and acts on the 2-bit next-PC select produced by the branch unit (00 JR, 01 J/JAL, 10 taken BEQ/BNE, 11 sequential).
- Picks the next fetch address and handles stalls from the hazard unit and instruction memory.
- On every redirect it flushes the younger in-flight instructions for a fixed number of cycles.
- Sits between the branch unit/decode stage and the instruction-memory address port.

Parameters:
- ADDR_W, 32, width of PC and all target inputs.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles flush stays high after a redirect (range 1..7).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_srcs  in  2  next-PC select from the branch unit: 00 JR, 01 J/JAL, 10 branch taken, 11 sequential.
- src_valid  in  1  pc_srcs is valid this cycle (a control instruction is in the decode/execute stage).
- jr_target  in  ADDR_W  register target for JR.
- j_target  in  ADDR_W  jump target for J/JAL.
- br_target  in  ADDR_W  branch target for BEQ/BNE.
- stall_in  in  1  hazard stall; hold the PC.
- imem_ready  in  1  instruction memory accepts an address this cycle.
- pc  out  ADDR_W  current fetch address.
- pc_valid  out  1  pc is a legal fetch address.
- flush  out  1  invalidate IF/ID contents.
- redirect  out  1  one-cycle pulse when a redirect is accepted.
- misalign  out  1  one-cycle pulse when the accepted target had bits [1:0] != 0.
- redirect_cnt  out  16  saturating count of accepted redirects.

Behaviour:
- States: BOOT, RUN, STALL, FLUSH. One state register plus a 3-bit flush counter.
- Reset (reset=1 at a clock edge):
  - pc=RESET_PC, pc_valid=0, flush=0, redirect=0, misalign=0, redirect_cnt=0.
  - Flush counter = 0, state = BOOT.
  - Reset wins over every other input, including in the middle of a flush or stall.
- BOOT: one cycle. pc_valid goes 1 and the state moves to RUN. pc is not incremented.
- Definitions:
  - adv = imem_ready & ~stall_in.
  - take = src_valid & (pc_srcs != 2'b11), evaluated only in RUN or STALL.
- RUN and STALL, priority order:
  1. take = 1:
     - pc <= selected target with bits [1:0] forced to 0.
     - redirect = 1 next cycle; misalign = 1 next cycle if the raw target had bits [1:0] != 0.
     - redirect_cnt increments, saturating at 16'hFFFF.
     - Flush counter <= FLUSH_CYCLES, state <= FLUSH.
     - The redirect is accepted even when adv = 0; the new pc is then held until adv.
  2. Else if adv = 0: pc holds, state <= STALL.
  3. Else: pc <= pc + 4, wrapping modulo 2^ADDR_W (32'hFFFF_FFFC wraps to 0). State <= RUN.
- FLUSH:
  - flush = 1 while the flush counter is non-zero.
  - The counter decrements every cycle, independent of adv.
  - src_valid/pc_srcs are ignored, because they come from flushed instructions.
  - pc advances by 4 only when adv = 1.
  - When the counter reaches 0: flush = 0 and state <= STALL if adv = 0, else RUN.
- Output timing:
  - flush rises the cycle after the redirect edge and lasts exactly FLUSH_CYCLES cycles.
  - redirect and misalign are registered single-cycle pulses.
  - pc is registered: latency from take to the new pc on the port is 1 cycle.
- Simultaneous take and stall_in: the redirect wins. The PC loads the target and is then held while stalled.
- pc_srcs = 11 with src_valid = 1 is treated as sequential.
- src_valid = 0 means pc_srcs is don't-care.

Test Plan:
- Reset for 2 cycles, release, imem_ready=1, stall_in=0:
  - pc=0 and pc_valid=0 during reset.
  - BOOT cycle: pc=0, pc_valid=1.
  - Then pc = 4, 8, 12 on successive cycles.
- At pc=0x10, src_valid=1, pc_srcs=10, br_target=0x40:
  - Next cycle: pc=0x40, redirect=1, redirect_cnt=1.
  - flush=1 for exactly 2 cycles, during which pc advances to 0x44, 0x48.
  - src_valid=1 with pc_srcs=01 driven during those flush cycles causes no redirect.
- stall_in=1 for 3 cycles at pc=0x20:
  - pc holds 0x20 for 3 cycles, then 0x24 the cycle after stall_in drops.
  - Repeat with imem_ready=0: same result.
- stall_in=1 together with src_valid=1, pc_srcs=00, jr_target=0x103:
  - Next cycle: pc=0x100, misalign=1, redirect=1.
  - pc holds 0x100 until the stall clears, then 0x104.
- Preload via redirect to 0xFFFF_FFF8, then run sequential:
  - pc goes 0xFFFF_FFFC, then 0x0000_0000.
- Assert reset while in FLUSH with the counter at 1:
  - Next cycle: flush=0, pc=RESET_PC, redirect_cnt=0.
  - Drive 65540 redirects: redirect_cnt saturates at 0xFFFF.
